// File: rtl/ser_link_pkg.sv
// rtl/ser_link_pkg.sv - shared serial link types and defaults for rx and future tx
package ser_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } link_state_e;

  localparam int DATA_W_DEF   = 8;
  localparam bit IDLE_LVL_DEF = 1'b1;

endpackage

// File: rtl/ser_rx_frame8.sv
// rtl/ser_rx_frame8.sv - strobe-timed serial frame receiver; SER_RX_PARITY_EN adds a parity bit
module ser_rx_frame8
  import ser_link_pkg::*;
#(
  parameter int   DATA_W   = DATA_W_DEF,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              ser_in,
  input  logic              msb_first,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
`ifdef SER_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int            CW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  link_state_e       state, state_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic [DATA_W-1:0] data_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              order, order_n;
  logic              valid_n;
  logic              frame_err_n;
`ifdef SER_RX_PARITY_EN
  logic              parity_err_n;
`endif

  // State and datapath registers; reset wins over any strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      order     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SER_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      order     <= order_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
`ifdef SER_RX_PARITY_EN
      parity_err <= parity_err_n;
`endif
    end
  end

  // Next-state logic: everything advances only on bit_en, valid is a single-cycle strobe
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    order_n     = order;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = frame_err;
`ifdef SER_RX_PARITY_EN
    parity_err_n = parity_err;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (ser_in != IDLE_LVL) begin
            order_n     = msb_first;
            cnt_n       = '0;
            frame_err_n = 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_err_n = 1'b0;
`endif
            state_n     = DATA;
          end
        end
        DATA: begin
          sr_n  = order ? {sr[DATA_W-2:0], ser_in} : {ser_in, sr[DATA_W-1:1]};
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef SER_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SER_RX_PARITY_EN
        PARITY: begin
          // Even parity: payload plus parity bit must XOR to zero
          parity_err_n = (^sr) ^ ser_in;
          state_n      = STOP;
        end
`endif
        STOP: begin
          if (ser_in == IDLE_LVL) begin
            data_n  = sr;
            valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Busy whenever a frame is in progress
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_ser_rx_frame8.sv
// tb/tb_ser_rx_frame8.sv - randomized self-checking bench for ser_rx_frame8
module tb_ser_rx_frame8;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       ser_in;
  logic       msb_first;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef SER_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  int valid_hi = 0;
  int busy_hi  = 0;

  ser_rx_frame8 dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .ser_in    (ser_in),
    .msb_first (msb_first),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef SER_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which valid / busy are high, sampled mid-cycle
  always @(negedge clk) begin
    if (valid === 1'b1) valid_hi++;
    if (busy === 1'b1) busy_hi++;
  end

  // Reference: word value from bits in transmit order (sent[7] goes first)
  function automatic logic [7:0] model_word(input logic [7:0] sent, input logic msb);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      if (sent[7-i]) v = v + (1 << (msb ? (7 - i) : i));
    end
    return v[7:0];
  endfunction

  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
    @(negedge clk);
    ser_in = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_en = 1'b0;
      ser_in = 1'b1;
    end
  endtask

  task automatic send_start(input logic msb, input int gap);
    msb_first = msb;
    drive_bit(1'b0, gap);
  endtask

  task automatic send_body(input logic [7:0] sent, input logic par, input logic stop, input int gap);
    for (int i = 7; i >= 0; i--) begin
      msb_first = 1'($urandom_range(0, 1));
      drive_bit(sent[i], gap);
    end
`ifdef SER_RX_PARITY_EN
    drive_bit(par, gap);
`else
    if (par === 1'bx) msb_first = 1'b0;
`endif
    drive_bit(stop, gap);
  endtask

  task automatic send_frame(input logic [7:0] sent, input logic msb, input logic par,
                            input logic stop, input int gap);
    send_start(msb, gap);
    send_body(sent, par, stop, gap);
  endtask

  task automatic test_reset;
    int v0, b0;
    rst = 1'b1; bit_en = 1'b0; ser_in = 1'b1; msb_first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_hi; b0 = busy_hi;
    for (int k = 0; k < 25; k++) begin
      drive_bit(1'b1, 3);
      if (k == 10) begin
        @(negedge clk); bit_en = 1'b0; ser_in = 1'b0;
        @(negedge clk); ser_in = 1'b1;
      end
    end
    idle_cycles(2);
    checks++; if (busy_hi - b0 != 0) begin failures++; $display("FAIL idle_busy got=%0d exp=0", busy_hi - b0); end
    checks++; if (valid_hi - v0 != 0) begin failures++; $display("FAIL idle_valid got=%0d exp=0", valid_hi - v0); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL idle_data got=%h exp=00", data); end
  endtask

  task automatic test_msb_first;
    int v0;
    v0 = valid_hi;
    send_start(1'b1, 3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL msb_busy got=%b exp=1", busy); end
    send_body(8'b1011_0010, 1'b0, 1'b1, 3);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'hB2) begin failures++; $display("FAIL msb_data got=%h exp=b2", data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL msb_frame_err got=%b exp=0", frame_err); end
    idle_cycles(3);
    checks++; if (valid_hi - v0 != 1) begin failures++; $display("FAIL msb_valid_cycles got=%0d exp=1", valid_hi - v0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL msb_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_lsb_first;
    send_frame(8'b1011_0010, 1'b0, 1'b0, 1'b1, 2);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'h4D) begin failures++; $display("FAIL lsb_data got=%h exp=4d", data); end
    idle_cycles(2);
  endtask

  task automatic test_frame_err;
    int v0;
    v0 = valid_hi;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    checks++; if (data !== 8'h4D) begin failures++; $display("FAIL ferr_data got=%h exp=4d", data); end
    idle_cycles(3);
    checks++; if (valid_hi - v0 != 0) begin failures++; $display("FAIL ferr_valid_cycles got=%0d exp=0", valid_hi - v0); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
    send_start(1'b1, 1);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
    send_body(8'h5A, 1'b0, 1'b1, 1);
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL ferr_next_data got=%h exp=5a", data); end
    idle_cycles(2);
  endtask

  task automatic test_abort;
    int v0;
    v0 = valid_hi;
    send_start(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; ser_in = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL abort_data got=%h exp=00", data); end
    @(negedge clk);
    rst = 1'b0; bit_en = 1'b0;
    idle_cycles(2);
    checks++; if (valid_hi - v0 != 0) begin failures++; $display("FAIL abort_valid got=%0d exp=0", valid_hi - v0); end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1);
    checks++; if (data !== 8'hFF) begin failures++; $display("FAIL abort_next_data got=%h exp=ff", data); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL abort_next_valid got=%b exp=1", valid); end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_data, sent;
    logic       msb, stop, par, exp_ferr;
`ifdef SER_RX_PARITY_EN
    logic       exp_perr;
`endif
    int v0, good;
    exp_data = 8'hFF;
    v0 = valid_hi; good = 0;
    for (int f = 0; f < 24; f++) begin
      sent = 8'($urandom);
      msb  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      par  = (^sent) ^ ($urandom_range(0, 3) == 0);
      send_frame(sent, msb, par, stop, 0);
      exp_ferr = ~stop;
      if (stop) begin
        exp_data = model_word(sent, msb);
        good++;
      end
`ifdef SER_RX_PARITY_EN
      exp_perr = (^sent) ^ par;
      checks++; if (parity_err !== exp_perr) begin failures++; $display("FAIL b2b_parity_err frame=%0d got=%b exp=%b", f, parity_err, exp_perr); end
`endif
      checks++; if (valid !== stop) begin failures++; $display("FAIL b2b_valid frame=%0d got=%b exp=%b", f, valid, stop); end
      checks++; if (data !== exp_data) begin failures++; $display("FAIL b2b_data frame=%0d got=%h exp=%h", f, data, exp_data); end
      checks++; if (frame_err !== exp_ferr) begin failures++; $display("FAIL b2b_frame_err frame=%0d got=%b exp=%b", f, frame_err, exp_ferr); end
    end
    idle_cycles(3);
    checks++; if (valid_hi - v0 != good) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=%0d", valid_hi - v0, good); end
  endtask

`ifdef SER_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1);
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_err_set got=%b exp=1", parity_err); end
    checks++; if (data !== 8'h03) begin failures++; $display("FAIL par_data got=%h exp=03", data); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL par_valid got=%b exp=1", valid); end
    idle_cycles(2);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_err_clear got=%b exp=0", parity_err); end
    idle_cycles(2);
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_frame_err();
    test_abort();
`ifdef SER_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_rx_frame8.md
Name: ser_rx_frame8

Overview:
- Serial-to-parallel receiver: the receiving end of the 8-bit shift-register serial link that drives the LED bank.
- Detects a start bit, shifts in DATA_W bits in a selectable bit order, and checks the stop bit.
- Presents the byte with a one-cycle valid strobe, for the 7-segment display or downstream logic.
- Bit timing comes from an external one-cycle strobe (e.g. derived from the clock divider), not from a local baud counter.

Parameters:
- DATA_W, 8, payload bits per frame.
- IDLE_LVL, 1, line level when idle; start bit = ~IDLE_LVL, stop bit = IDLE_LVL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  one-cycle strobe, once per bit period; line sampled only when high.
- ser_in  input  1  serial line.
- msb_first  input  1  bit order, latched on start detect (1 = MSB first, like a left shift; 0 = LSB first).
- data  output  DATA_W  last good received word.
- valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  sticky; set on bad stop bit.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset: state=IDLE, data=0, valid=0, frame_err=0, busy=0, shift register=0, bit counter=0.
- States: IDLE, DATA, (PARITY), STOP. Transitions occur only on cycles with bit_en=1; otherwise all state holds.
- IDLE: on bit_en with ser_in=~IDLE_LVL:
  - latch msb_first, clear counter, go to DATA.
  - Clear frame_err, so each frame reports its own error.
- DATA: on each bit_en, shift in ser_in.
  - msb_first=1: sr <= {sr[DATA_W-2:0], ser_in}.
  - msb_first=0: sr <= {ser_in, sr[DATA_W-1:1]}.
  - Counter increments; after DATA_W samples go to STOP (or PARITY).
- STOP: on bit_en:
  - If ser_in=IDLE_LVL: data <= sr and valid=1 in the next cycle (exactly one clk wide).
  - Else: frame_err <= 1 and data unchanged.
  - Either way return to IDLE.
- Latency: valid asserts 1 clk after the bit_en that samples the stop bit.
- Back-to-back frames: a start bit on the bit_en immediately after STOP is accepted; there is no mandatory idle gap.
- bit_en held high continuously: one bit per clk, still legal.
- A glitch low in IDLE while bit_en=0 is ignored.
- rst asserted mid-frame: immediate return to reset values on the next edge; the partial word is discarded and valid is never pulsed.
- rst has priority over bit_en.
- msb_first changes mid-frame have no effect until the next start.

Optional Feature:
- Macro SER_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; it samples one even-parity bit.
  - Output parity_err (1 bit, sticky like frame_err, cleared on start) is set if XOR(payload, parity bit) != 0.
  - data and valid still update if the stop bit is good; consumers check parity_err.
- Undefined: no PARITY state; DATA goes straight to STOP; parity_err port absent.

Decomposition:
- Shared package ser_link_pkg: state enum (IDLE, DATA, PARITY, STOP), localparam DATA_W_DEF=8, IDLE_LVL_DEF=1.
- The future matching transmitter reuses the same package.
- Single FSM with an inline shifter; no sub-module needed.
- The counter width is $clog2(DATA_W+1), computed locally.

Test Plan:
- Reset then idle line high, bit_en every 4 clk for 100 clk -> busy=0, valid never pulses, data=0.
- Frame start(0), bits 1,0,1,1,0,0,1,0 (sent in order), stop(1), with msb_first=1 -> data=8'hB2, one valid pulse 1 clk after the stop sample, frame_err=0.
- Same bit sequence with msb_first=0 -> data=8'h4D.
- Stop bit sampled 0 -> frame_err=1, valid stays 0, data keeps the previous value (8'h4D). The next good frame 8'h5A clears frame_err and yields data=8'h5A.
- Assert rst after 4 data bits -> busy=0 the next clk. A following frame 8'hFF is received intact, with no residue from the aborted frame.
- With SER_RX_PARITY_EN: payload 8'h03 with parity bit 1 -> parity_err=1, data=8'h03, valid pulses. With parity bit 0 -> parity_err=0.
